// File: rtl/iob_uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_core transmitter among N_REQ byte-stream requesters.
// A granted requester keeps the transmitter until a last-flagged byte or MAX_BURST bytes.
module iob_uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int HOLDOFF   = 2
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    soft_rst_i,
    input  logic                    en_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    input  logic                    tx_ready_i,
    output logic [DATA_W-1:0]       tx_data_o,
    output logic                    tx_wen_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 2);
    localparam int HLD_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_HOLD} state_t;

    state_t              r_state, w_state;
    logic [PTR_W-1:0]    r_ptr, w_ptr;
    logic [PTR_W-1:0]    r_owner, w_owner;
    logic [N_REQ-1:0]    r_grant, w_grant;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_release, w_release;
    logic [HLD_W-1:0]    r_hold, w_hold;
    logic [DATA_W-1:0]   r_tx_data, w_tx_data;
    logic                r_tx_wen, w_tx_wen;

    logic                w_found;
    logic [PTR_W-1:0]    w_pick;
    logic                w_xfer;
    logic                w_burst_end;
    logic [DATA_W-1:0]   w_owner_data;

    // Scan ptr, ptr+1, ... wrapping, and take the first valid requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid_i[(int'(r_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_owner_data = req_data_i[r_owner*DATA_W +: DATA_W];
    assign w_xfer       = (r_state == S_LOCK) && en_i && tx_ready_i && req_valid_i[r_owner];
    assign w_burst_end  = (MAX_BURST != 0) && (int'(r_cnt) + 1 == MAX_BURST);

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_grant   = r_grant;
        w_cnt     = r_cnt;
        w_release = r_release;
        w_hold    = r_hold;
        w_tx_data = r_tx_data;
        w_tx_wen  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i && w_found) begin
                    w_state = S_LOCK;
                    w_owner = w_pick;
                    w_grant = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_cnt   = '0;
                end
            end
            S_LOCK: begin
                if (w_xfer) begin
                    w_tx_data = w_owner_data;
                    w_tx_wen  = 1'b1;
                    w_cnt     = r_cnt + 1'b1;
                    w_release = req_last_i[r_owner] | w_burst_end;
                    w_hold    = HLD_W'(HOLDOFF);
                    w_state   = S_HOLD;
                end
            end
            S_HOLD: begin
                // Core ready is stale for HOLDOFF cycles after the write pulse.
                if (r_hold != '0) begin
                    w_hold = r_hold - 1'b1;
                end else if (tx_ready_i) begin
                    if (r_release) begin
                        w_state = S_IDLE;
                        w_grant = '0;
                        w_ptr   = (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
                    end else begin
                        w_state = S_LOCK;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_release <= 1'b0;
            r_hold    <= '0;
            r_tx_data <= '0;
            r_tx_wen  <= 1'b0;
        end else if (cke_i) begin
            if (soft_rst_i) begin
                r_state   <= S_IDLE;
                r_ptr     <= '0;
                r_owner   <= '0;
                r_grant   <= '0;
                r_cnt     <= '0;
                r_release <= 1'b0;
                r_hold    <= '0;
                r_tx_data <= '0;
                r_tx_wen  <= 1'b0;
            end else begin
                r_state   <= w_state;
                r_ptr     <= w_ptr;
                r_owner   <= w_owner;
                r_grant   <= w_grant;
                r_cnt     <= w_cnt;
                r_release <= w_release;
                r_hold    <= w_hold;
                r_tx_data <= w_tx_data;
                r_tx_wen  <= w_tx_wen;
            end
        end
    end

    assign req_ready_o = (r_state == S_LOCK && en_i && tx_ready_i) ? r_grant : '0;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != S_IDLE);
    assign tx_data_o   = r_tx_data;
    assign tx_wen_o    = r_tx_wen;

endmodule
